// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - valid/ready byte stream carried from the UART receiver
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // Receiver drives the byte and its valid flag; the consumer drives ready.
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling serial receiver, 8N1 (8E1 with UART_RX_PARITY_EN)
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      ser_rx,
  uart_rx_if.master rx,
  output logic      frame_err,
`ifdef UART_RX_PARITY_EN
  output logic      parity_err,
`endif
  output logic      overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: CLK_FREQ/(BAUD*16) must be at least 2");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t          state_q, state_d;
  logic            meta_q, rx_s_q, rx_prev_q;
  logic [TW-1:0]   tcnt_q;
  logic [3:0]      scnt_q;
  logic [2:0]      bidx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q, ferr_q, ovr_q;

  logic tick, mid;
  logic clr_cnt, bidx_clr, shift_en, byte_done, ferr_set;

`ifdef UART_RX_PARITY_EN
  logic par_q, perr_q, par_en, perr_set, par_ok;
  assign par_ok = ~^{shift_q, par_q};
`endif

  assign tick = (tcnt_q == TW'(DIV - 1));
  assign mid  = tick && (scnt_q == 4'd7);

  // Two-flop synchronizer plus a delayed copy for start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      meta_q    <= ser_rx;
      rx_s_q    <= meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control strobes; every decision uses rx_s_q.
  always_comb begin
    state_d   = state_q;
    clr_cnt   = 1'b0;
    bidx_clr  = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
    perr_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          clr_cnt = 1'b1;
        end
      end
      S_START: begin
        if (mid) begin
          if (!rx_s_q) begin
            state_d  = S_DATA;
            bidx_clr = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_en = 1'b1;
          if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          par_en  = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          if (rx_s_q) begin
            // Returning to IDLE here leaves half a bit to catch the next start edge.
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            byte_done = par_ok;
            perr_set  = !par_ok;
`else
            byte_done = 1'b1;
`endif
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Oversample tick and sample counters, phase-aligned to the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
      scnt_q <= '0;
    end else if (clr_cnt) begin
      tcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
      if (tick) scnt_q <= scnt_q + 4'd1;
    end
  end

  // Data shift register, LSB first on the wire, and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      bidx_q  <= '0;
    end else begin
      if (bidx_clr) bidx_q <= '0;
      else if (shift_en) bidx_q <= bidx_q + 3'd1;
      if (shift_en) shift_q <= {rx_s_q, shift_q[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity bit capture and parity error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (par_en) par_q <= rx_s_q;
      perr_q <= perr_set;
    end
  end

  assign parity_err = perr_q;
`endif

  // Holding register with valid/ready handshake, framing and overrun pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_set;
      ovr_q  <= 1'b0;
      if (byte_done) begin
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 32 clocks per bit
module tb_uart_rx;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 50000;
  localparam int BIT      = 32;

  logic clk = 1'b0;
  logic reset;
  logic ser_rx;
  logic frame_err;
  logic overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx_if rxif();

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .rx        (rxif),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  int ferr_seen = 0, ovr_seen = 0, perr_seen = 0;
  int ferr_exp  = 0, ovr_exp  = 0, perr_exp  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: counts flag pulses and pops the scoreboard on each accepted byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_seen++;
`endif
      if (rxif.rx_valid && rxif.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got 0x%0h, no byte expected", rxif.rx_data);
        end else begin
          check("rx_data", {24'd0, rxif.rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    ser_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int par);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
    if (par >= 0) drive_bit(par[0], BIT);
    drive_bit(1'b1, BIT);
  endtask

  task automatic checkpoint(string name);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_frame_err"}, ferr_seen, ferr_exp);
    check({name, "_overrun"}, ovr_seen, ovr_exp);
    check({name, "_parity_err"}, perr_seen, perr_exp);
  endtask

  initial begin
    reset = 1'b1;
    ser_rx = 1'b1;
    rxif.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_valid", {31'd0, rxif.rx_valid}, 0);
    check("reset_rx_data", {24'd0, rxif.rx_data}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_overrun", {31'd0, overrun}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_bit(1'b1, 8);

    // 1: single byte with consumer always ready.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, -1);
    drive_bit(1'b1, 8);
    check("t1_valid_dropped", {31'd0, rxif.rx_valid}, 0);
    checkpoint("t1");

    // 2: two back-to-back bytes with consumer stalled; second overruns.
    rxif.rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, -1);
    send_frame(8'hC3, -1);
    ovr_exp = 1;
    drive_bit(1'b1, 8);
    @(negedge clk);
    check("t2_valid_held", {31'd0, rxif.rx_valid}, 1);
    check("t2_data_held", {24'd0, rxif.rx_data}, 32'h3C);
    @(posedge clk); #1;
    rxif.rx_ready = 1'b1;
    @(posedge clk); #1;
    rxif.rx_ready = 1'b0;
    @(negedge clk);
    check("t2_valid_cleared", {31'd0, rxif.rx_valid}, 0);
    rxif.rx_ready = 1'b1;
    checkpoint("t2");

    // 3: start glitch shorter than half a bit, then a real byte.
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 40);
    check("t3_no_valid", {31'd0, rxif.rx_valid}, 0);
    checkpoint("t3a");
    exp_q.push_back(8'h55);
    send_frame(8'h55, -1);
    drive_bit(1'b1, 8);
    checkpoint("t3b");

    // 4: stop bit held low for two bit times -> framing error, then recovery.
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(((8'h81 >> i) & 8'h01) != 0, BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0, BIT);
`endif
    drive_bit(1'b0, 2 * BIT);
    ferr_exp = 1;
    drive_bit(1'b1, BIT);
    check("t4_no_valid", {31'd0, rxif.rx_valid}, 0);
    checkpoint("t4a");
    exp_q.push_back(8'h7E);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h7E, 0);
`else
    send_frame(8'h7E, -1);
`endif
    drive_bit(1'b1, 8);
    checkpoint("t4b");

    // 5: reset in the middle of data bit 3 of 0xFF, then a clean byte.
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, 3 * BIT + 16);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_bit(1'b1, 16 + 5 * BIT);
    check("t5_no_valid", {31'd0, rxif.rx_valid}, 0);
    exp_q.push_back(8'h12);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h12, 0);
`else
    send_frame(8'h12, -1);
`endif
    drive_bit(1'b1, 8);
    checkpoint("t5");

`ifdef UART_RX_PARITY_EN
    // 6: even parity accepted, wrong parity rejected.
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1);
    drive_bit(1'b1, 8);
    checkpoint("t6a");
    send_frame(8'h07, 0);
    perr_exp = 1;
    drive_bit(1'b1, 8);
    check("t6_no_valid", {31'd0, rxif.rx_valid}, 0);
    checkpoint("t6b");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver for the `ser_rx` pin of the top level. It is the counterpart of the existing serial transmit path on `ser_tx`.
- Oversamples the line at 16x the baud rate and recovers bytes. Delivers each byte on a valid/ready interface to the command/register logic.
- Flags framing errors and overrun.

Parameters:
- CLK_FREQ, 100000000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- DIV (localparam), CLK_FREQ/(BAUD*16), truncated: clocks per oversample tick. Must be >= 2; a compile-time check fails elaboration otherwise.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ser_rx  in  1  asynchronous serial input; idle high.
- rx_data  out  8  received byte; LSB was first on the wire.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the holding register was full; that byte is dropped.

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-high (`reset`).
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops=1.
  - FSM=IDLE; tick and bit counters=0.
  - Asserting reset mid-frame abandons the frame silently.
- Input path: 2-flop synchronizer, reset to 1. All FSM decisions use the synchronized value `rx_s`.
- Tick generator:
  - Counter 0..DIV-1 produces a one-clock `tick` at count DIV-1.
  - The counter is cleared when IDLE detects a start edge, so sampling phase aligns to that edge.
- Sample counter: `scnt`, 4 bits, advances on each tick. A bit's mid-point is the tick on which scnt reaches 7 from the bit's first tick. Subsequent samples follow every 16 ticks.
- FSM states:
  - IDLE: a high-to-low transition of rx_s (previous 1, current 0) goes to START and clears the tick and sample counters.
  - START: at mid-point, rx_s=0 goes to DATA with bit index 0. rx_s=1 is a glitch: return to IDLE with no flags.
  - DATA: at each mid-point, shift rx_s into the shift register MSB, shifting right, so the first bit lands in bit 0 after 8 bits. After bit index 7, go to STOP.
  - STOP, at mid-point:
    - rx_s=1: byte complete; go to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. No new start is detected while in BREAK.
- Byte delivery, in the clock after the STOP mid-point:
  - rx_valid=0: load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in that same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data, pulse overrun, drop the new byte.
- Handshake:
  - rx_valid clears the cycle after rx_valid && rx_ready, unless a new byte loads in the same cycle.
  - rx_data is stable while rx_valid=1 and not accepted.
- Back-to-back frames: IDLE is reached at the stop-bit mid-point, so a start edge half a bit later is caught. Tolerates about ±3% baud mismatch.
- Latency:
  - rx_valid rises 1 clock after the stop-bit mid-point tick.
  - That tick falls about 2 synchronizer clocks + (9*16+8)*DIV clocks after the line's start edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state between DATA and STOP samples one extra bit. If the XOR of the 8 data bits and the parity bit is 1, the byte is discarded and a one-cycle `parity_err` output pulses at the stop mid-point. A framing error takes precedence and suppresses parity_err. parity_err resets to 0 and exists only under the macro.
- Undefined: 8N1 exactly as above; no PARITY state and no parity_err port.

Test Plan:
All cases use CLK_FREQ=1600000 and BAUD=50000, giving DIV=2 and 32 clocks per bit.
1. Send 0xA5 8N1, rx_ready=1 -> rx_valid pulses for one cycle with rx_data=0xA5; frame_err=0; overrun=0.
2. Send 0x3C then 0xC3 back-to-back, rx_ready=0 until both are done -> rx_data stays 0x3C, overrun pulses once at the second stop bit. Then raise rx_ready for 1 cycle -> rx_valid drops.
3. Drive ser_rx low for 10 clocks (under a half bit), then high -> no rx_valid, no frame_err; FSM back in IDLE. A subsequent 0x55 is received correctly.
4. Send 0x81 with the stop bit held low for 2 bit times, then high -> frame_err pulses once; rx_valid stays 0. A following 0x7E is received as 0x7E.
5. Assert reset for 1 clock mid-way through data bit 3 of 0xFF, then send 0x12 -> no byte delivered for the aborted frame; rx_data=0x12 delivered; all flags 0.
6. With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> delivered. Send 0x07 with parity bit 0 -> parity_err pulse, rx_valid stays 0.
